// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for a byte-cell data memory.
// Accepts one load/store (byte, half word or word) and serialises it into one-byte accesses,
// one per cycle. Loads are reassembled little-endian and sign- or zero-extended.
//
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_req_valid, i_req_write    request present (sampled in IDLE only); 1 = store
//   i_size, i_unsigned          00 byte / 01 half / 10 word / 11 invalid; zero-extend loads
//   i_addr, i_wdata             byte address; store data (low bytes used per size)
//   o_busy, o_done, o_error     stall; one-cycle completion pulse; error qualifier for o_done
//   o_rdata                     extended load result, held until the next successful load
//   o_mem_addr, o_mem_we        byte address and write enable toward memory
//   o_mem_wdata, i_mem_rdata    byte to write; byte read back combinationally
module mem_access_unit #(
  parameter int unsigned WORD_LEN      = 32,
  parameter int unsigned MEM_CELL_SIZE = 8,
  parameter bit          ALIGN_CHECK   = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  input  logic                     i_req_write,
  input  logic [1:0]               i_size,
  input  logic                     i_unsigned,
  input  logic [WORD_LEN-1:0]      i_addr,
  input  logic [WORD_LEN-1:0]      i_wdata,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [WORD_LEN-1:0]      o_rdata,
  output logic [WORD_LEN-1:0]      o_mem_addr,
  output logic                     o_mem_we,
  output logic [MEM_CELL_SIZE-1:0] o_mem_wdata,
  input  logic [MEM_CELL_SIZE-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e                state_q, state_d;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [WORD_LEN-1:0]   wdata_q;    // shifted right one byte per access cycle
  logic [WORD_LEN-1:0]   mem_addr_q; // addr + k during ACCESS, holds otherwise
  logic [1:0]            k_q;
  logic                  err_q;
  logic [WORD_LEN-1:0]   asm_q;
  logic [WORD_LEN-1:0]   rdata_q;

  logic                  req_err;
  logic [1:0]            last_k;
  logic                  last_byte;
  logic [WORD_LEN-1:0]   asm_full;
  logic                  sign_bit;
  logic [WORD_LEN-1:0]   rdata_ext;

  // Request check on the incoming (not yet registered) request.
  always_comb begin
    req_err = 1'b0;
    case (i_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = ALIGN_CHECK && i_addr[0];
      2'b10:   req_err = ALIGN_CHECK && (i_addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
  end

  always_comb begin
    last_k = 2'd0;
    case (size_q)
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  assign last_byte = (k_q == last_k);

  // Assembly register with this cycle's byte merged in, so the final byte can feed o_rdata
  // on the same edge that leaves ACCESS.
  always_comb begin
    asm_full = asm_q;
    case (k_q)
      2'd0:    asm_full[7:0]   = i_mem_rdata;
      2'd1:    asm_full[15:8]  = i_mem_rdata;
      2'd2:    asm_full[23:16] = i_mem_rdata;
      default: asm_full[31:24] = i_mem_rdata;
    endcase
  end

  always_comb begin
    sign_bit  = 1'b0;
    rdata_ext = asm_full;
    case (size_q)
      2'b00: begin
        sign_bit  = asm_full[7] & ~unsigned_q;
        rdata_ext = {{(WORD_LEN-8){sign_bit}}, asm_full[7:0]};
      end
      2'b01: begin
        sign_bit  = asm_full[15] & ~unsigned_q;
        rdata_ext = {{(WORD_LEN-16){sign_bit}}, asm_full[15:0]};
      end
      default: begin
        sign_bit  = 1'b0;
        rdata_ext = asm_full;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          state_d = req_err ? StDone : StAccess;
        end
      end
      StAccess: begin
        if (last_byte) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      mem_addr_q <= '0;
      k_q        <= 2'd0;
      err_q      <= 1'b0;
      asm_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (i_req_valid) begin
            write_q    <= i_req_write;
            size_q     <= i_size;
            unsigned_q <= i_unsigned;
            wdata_q    <= i_wdata;
            k_q        <= 2'd0;
            err_q      <= req_err;
            // A rejected request never reaches memory, so the address bus keeps its last value.
            if (!req_err) begin
              mem_addr_q <= i_addr;
            end
          end
        end
        StAccess: begin
          asm_q <= asm_full;
          if (!last_byte) begin
            k_q        <= k_q + 2'd1;
            mem_addr_q <= mem_addr_q + WORD_LEN'(1);
            wdata_q    <= wdata_q >> MEM_CELL_SIZE;
          end else if (!write_q) begin
            rdata_q <= rdata_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (state_q != StIdle);
  assign o_done      = (state_q == StDone);
  assign o_error     = (state_q == StDone) && err_q;
  assign o_rdata     = rdata_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_we    = (state_q == StAccess) && write_q;
  assign o_mem_wdata = (state_q == StAccess) ? wdata_q[MEM_CELL_SIZE-1:0] : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. Two instances share the request inputs:
// instance 0 with alignment checking, instance 1 performing misaligned accesses byte by byte.
// Each has its own 256-byte memory (address bits [7:0]); a reference model predicts errors,
// latency, per-cycle byte accesses and the extended load result.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        busy   [2];
  logic        done   [2];
  logic        error  [2];
  logic [31:0] rdata  [2];
  logic [31:0] maddr  [2];
  logic        mwe    [2];
  logic [7:0]  mwdata [2];
  logic [7:0]  mrdata [2];

  logic [7:0]  mem       [2][256];
  logic [7:0]  ref_mem   [2][256];
  logic [31:0] exp_rdata [2];
  bit          mem_init;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WORD_LEN(32), .MEM_CELL_SIZE(8), .ALIGN_CHECK(1'b1)) u_dut_chk (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_write(req_write),
    .i_size(req_size), .i_unsigned(req_unsigned), .i_addr(req_addr), .i_wdata(req_wdata),
    .o_busy(busy[0]), .o_done(done[0]), .o_error(error[0]), .o_rdata(rdata[0]),
    .o_mem_addr(maddr[0]), .o_mem_we(mwe[0]), .o_mem_wdata(mwdata[0]), .i_mem_rdata(mrdata[0])
  );

  mem_access_unit #(.WORD_LEN(32), .MEM_CELL_SIZE(8), .ALIGN_CHECK(1'b0)) u_dut_nochk (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_write(req_write),
    .i_size(req_size), .i_unsigned(req_unsigned), .i_addr(req_addr), .i_wdata(req_wdata),
    .o_busy(busy[1]), .o_done(done[1]), .o_error(error[1]), .o_rdata(rdata[1]),
    .o_mem_addr(maddr[1]), .o_mem_we(mwe[1]), .o_mem_wdata(mwdata[1]), .i_mem_rdata(mrdata[1])
  );

  function automatic logic [7:0] init_byte(input int j);
    return 8'((j * 73 + 29) ^ (j >> 3));
  endfunction

  // Memory: combinational read, write on the clock edge.
  assign mrdata[0] = mem[0][maddr[0][7:0]];
  assign mrdata[1] = mem[1][maddr[1][7:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int j = 0; j < 256; j++) begin
        mem[0][j] <= init_byte(j);
        mem[1][j] <= init_byte(j);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mwe[i]) mem[i][maddr[i][7:0]] <= mwdata[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s i%0d busy", tag, i), 32'(busy[i]), 32'd0);
      check($sformatf("%s i%0d done", tag, i), 32'(done[i]), 32'd0);
      check($sformatf("%s i%0d error", tag, i), 32'(error[i]), 32'd0);
      check($sformatf("%s i%0d we", tag, i), 32'(mwe[i]), 32'd0);
      check($sformatf("%s i%0d rdata", tag, i), rdata[i], 32'd0);
      check($sformatf("%s i%0d maddr", tag, i), maddr[i], 32'd0);
      check($sformatf("%s i%0d wdata", tag, i), 32'(mwdata[i]), 32'd0);
    end
  endtask

  // Issue one request (called just after a falling edge with both units idle). keep holds
  // i_req_valid high for the whole transaction and its DONE cycle.
  task automatic run_req(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit keep);
    bit          exp_err [2];
    int          n       [2];
    int          k       [2];
    bit          fin     [2];
    logic [31:0] val;
    logic [7:0]  idx;
    bit          misal;
    misal = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    for (int i = 0; i < 2; i++) begin
      exp_err[i] = (sz == 2'd3) || (i == 0 && misal);
      n[i]       = (sz == 2'd3) ? 0 : (1 << sz);
      k[i]       = 0;
      fin[i]     = 1'b0;
      if (!exp_err[i]) begin
        val = 32'd0;
        for (int b = 0; b < n[i]; b++) begin
          idx = a[7:0] + 8'(b);
          if (wr) ref_mem[i][idx] = 8'(wd >> (8 * b));
          else    val = val | (32'(ref_mem[i][idx]) << (8 * b));
        end
        if (!wr) begin
          if (n[i] < 4 && !uns && val[8*n[i]-1]) val = val | (32'hFFFF_FFFF << (8 * n[i]));
          exp_rdata[i] = val;
        end
      end
    end

    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;

    for (int cyc = 1; cyc <= 12 && !(fin[0] && fin[1]); cyc++) begin
      @(posedge clk);
      #1;
      if (!keep) req_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!fin[i]) begin
          if (done[i]) begin
            fin[i] = 1'b1;
            check($sformatf("i%0d latency", i), 32'(cyc), exp_err[i] ? 32'd1 : 32'(1 + n[i]));
            check($sformatf("i%0d error", i), 32'(error[i]), 32'(exp_err[i]));
            check($sformatf("i%0d busy@done", i), 32'(busy[i]), 32'd1);
            check($sformatf("i%0d bytes", i), 32'(k[i]), exp_err[i] ? 32'd0 : 32'(n[i]));
            check($sformatf("i%0d rdata", i), rdata[i], exp_rdata[i]);
            check($sformatf("i%0d we@done", i), 32'(mwe[i]), 32'd0);
          end else begin
            check($sformatf("i%0d busy", i), 32'(busy[i]), 32'd1);
            check($sformatf("i%0d addr k%0d", i, k[i]), maddr[i], a + 32'(k[i]));
            check($sformatf("i%0d we k%0d", i, k[i]), 32'(mwe[i]), 32'(wr));
            if (wr) check($sformatf("i%0d wbyte k%0d", i, k[i]), 32'(mwdata[i]),
                          (wd >> (8 * k[i])) & 32'hFF);
            k[i]++;
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) check($sformatf("i%0d done seen", i), 32'(fin[i]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("i%0d idle", i), 32'(busy[i]), 32'd0);
  endtask

  initial begin
    bit          wr;
    bit          uns;
    bit          keep;
    bit          misal;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;

    rst          = 1'b1;
    mem_init     = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    for (int i = 0; i < 2; i++) begin
      exp_rdata[i] = 32'd0;
      for (int j = 0; j < 256; j++) ref_mem[i][j] = init_byte(j);
    end
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    mem_init = 1'b0;
    rst      = 1'b0;
    @(negedge clk);

    // Word store then load.
    run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    // Signed / unsigned byte.
    run_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h80, 1'b0);
    run_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0);
    run_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0);
    // Half-word sign.
    run_req(1'b1, 2'b01, 1'b0, 32'h30, 32'h9234, 1'b0);
    run_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b0);
    run_req(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1'b0);
    // Misaligned word and invalid size.
    run_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b0);
    run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1'b0);
    run_req(1'b1, 2'b10, 1'b0, 32'h22, 32'h1122_3344, 1'b0);
    // Address wrap with valid held high through busy and DONE.
    run_req(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFE, 32'h0000_A55A, 1'b1);
    run_req(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFE, 32'h0, 1'b0);

    // Reset during the second byte of a word store: only byte 0 lands.
    wd           = 32'h1357_9BDF;
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h40;
    req_wdata    = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    for (int i = 0; i < 2; i++) begin
      ref_mem[i][8'h40] = wd[7:0];
      exp_rdata[i]      = 32'd0;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("i%0d rst byte0", i), 32'(mem[i][8'h40]), 32'(wd[7:0]));
      check($sformatf("i%0d rst byte1", i), 32'(mem[i][8'h41]), 32'(ref_mem[i][8'h41]));
    end
    @(negedge clk);
    run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);

    // Randomised traffic, including addresses near the top of the address space.
    for (int t = 0; t < 60; t++) begin
      wr    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      sz    = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                          : 32'($urandom_range(0, 255));
      wd    = $urandom;
      misal = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
      keep  = !misal && (t != 59) && ($urandom_range(0, 1) == 1);
      run_req(wr, sz, uns, a, wd, keep);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the byte-cell data memory port, placed in the MEM stage between the pipeline and the byte-addressed data memory. It accepts one load/store request (byte, half word or word) from the pipeline and serialises it into single-byte memory accesses, one per cycle. For loads it reassembles the bytes little-endian and sign- or zero-extends them. It holds the pipeline stalled (busy) until the access completes.

Parameters:
WORD_LEN, 32, pipeline data and address width (fixed at 32; other values unsupported)
MEM_CELL_SIZE, 8, width of one memory cell and of the memory data port
ALIGN_CHECK, 1, 1 = misaligned half/word raises an error; 0 = misaligned accesses are performed byte by byte

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_req_valid  in  1  request present (sampled only in IDLE)
i_req_write  in  1  1 = store, 0 = load
i_size  in  2  00 byte, 01 half word, 10 word, 11 invalid
i_unsigned  in  1  1 = zero-extend load, 0 = sign-extend load
i_addr  in  WORD_LEN  byte address
i_wdata  in  WORD_LEN  store data; low bytes used per size
o_busy  out  1  1 while a request is in flight (pipeline stall)
o_done  out  1  one-cycle completion pulse
o_error  out  1  valid with o_done: invalid size or misaligned
o_rdata  out  WORD_LEN  extended load result
o_mem_addr  out  WORD_LEN  byte address to memory
o_mem_we  out  1  memory write enable, this cycle's byte
o_mem_wdata  out  MEM_CELL_SIZE  byte to write
i_mem_rdata  in  MEM_CELL_SIZE  byte read from o_mem_addr, combinational, same cycle

Behaviour:
- Reset (async, any state): state IDLE; o_busy, o_done, o_error, o_mem_we = 0; o_rdata, o_mem_addr, o_mem_wdata = 0; byte counter and request registers = 0. A store interrupted by reset leaves already-written bytes in memory; remaining bytes are not written.
- States: IDLE, ACCESS, DONE. o_busy = (state != IDLE).
- IDLE: if i_req_valid, register write, size, unsigned, addr, wdata; clear byte counter k.
  - Error if size = 11, or if ALIGN_CHECK = 1 and (size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 00). On error go to DONE with error flag set; no memory access occurs.
  - Otherwise go to ACCESS.
  - i_req_valid low: stay in IDLE.
- ACCESS: number of bytes N = 1/2/4 for size 00/01/10.
  - In cycle k drive o_mem_addr = addr + k (modulo 2^32 wrap), and o_mem_we = write.
  - o_mem_wdata = wdata[8k+7:8k].
  - For a load, capture i_mem_rdata into byte lane k of an internal shift/assembly register at the clock edge ending cycle k.
  - After cycle N-1 go to DONE.
  - o_mem_we is 0 in every state other than ACCESS. o_mem_addr holds its last value outside ACCESS.
- DONE (one cycle): o_done = 1, o_error = error flag. Next state IDLE.
  - On a successful load, o_rdata is updated registered on entry to DONE, so it is visible in the DONE cycle.
  - Byte load: o_rdata = {24{s}, b0}. Half-word load: {16{s}, b1, b0}. Word load: {b3, b2, b1, b0}.
  - s = MSB of the highest loaded byte AND NOT unsigned.
  - o_rdata is unchanged by stores and errors, and holds until the next successful load.
- Latency from the accept edge to the o_done cycle: 1 + N cycles for a valid access; 1 cycle for an error.
- Requests arriving while busy are ignored; the pipeline must hold them until o_busy = 0. A request presented in the DONE cycle is accepted on the following IDLE cycle.

Test Plan:
- Word store then load: store addr 0x10, wdata 0xDEADBEEF -> memory writes 0xEF, 0xBE, 0xAD, 0xDE at 0x10..0x13 over 4 cycles. Then load word at 0x10 -> o_done 5 cycles after accept, o_rdata = 0xDEADBEEF, o_error = 0.
- Signed/unsigned byte: memory[0x20] = 0x80. Signed byte load -> o_rdata = 0xFFFFFF80. Unsigned byte load -> 0x00000080. o_busy is high for exactly 2 cycles.
- Half-word sign: memory[0x30..0x31] = 0x34, 0x92. Signed half-word load -> 0xFFFF9234. Unsigned half-word load -> 0x00009234.
- Errors: word load at 0x22 with ALIGN_CHECK = 1 -> o_done and o_error pulse 1 cycle after accept, o_mem_we never asserted, o_rdata unchanged. Size 11 -> same response. With ALIGN_CHECK = 0, word at 0x22 -> bytes 0x22..0x25 are accessed.
- Wrap-around and back-pressure: half-word store at 0xFFFFFFFE -> writes at 0xFFFFFFFE then 0xFFFFFFFF. A second request held high during busy is accepted only once, after DONE.
- Async reset mid-store: assert i_rst in the 2nd ACCESS cycle of a word store -> outputs go to 0 immediately, only byte 0 is written; after release, a new request completes normally.
